// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Purpose : Shared constants and types for the 4-to-1 stream multiplexer.
//           The channel count and select width are fixed here so that the
//           arbiter and the mux cannot disagree about them.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // EMPTY: the output register holds no word. FULL: it holds one.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } mux_state_t;

endpackage : mux_pkg

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
// Purpose : Purely combinational round-robin grant for four requesters.
//           The search starts at ptr and wraps, so the channel just after the
//           last winner has top priority.
// Ports   : req      in  [3:0]  request per channel
//           ptr      in  [1:0]  first channel to consider
//           gnt      out [1:0]  index of the granted channel (0 if none)
//           any_req  out        at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter_4
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt,
    output logic             any_req
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // Walk ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps 3 -> 0 for free.
    always_comb begin
        gnt     = '0;
        any_req = |req;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                gnt     = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_4

// File: rtl/stream_mux_4to1.sv
// -----------------------------------------------------------------------------
// stream_mux_4to1
// Purpose : Merges four valid/ready input streams into one registered output
//           stream using round-robin arbitration. One word per cycle is
//           sustained when the downstream keeps out_ready high.
// Ports   : clk        in               rising-edge clock
//           rst        in               synchronous active-high reset
//           En         in               global enable for accepting input
//           in_valid   in  [3:0]        per-channel valid
//           in_data    in  [4*WIDTH-1:0] channel i at [i*WIDTH +: WIDTH]
//           in_ready   out [3:0]        one-hot accept strobe (combinational)
//           out_valid  out              output register holds a word
//           out_data   out [WIDTH-1:0]  registered word
//           out_sel    out [1:0]        channel the word came from
//           out_ready  in               downstream accepts the word
// -----------------------------------------------------------------------------
module stream_mux_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  En,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    mux_state_t       r_state;
    mux_state_t       w_nextState;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_gnt;
    logic             w_anyReq;
    logic             w_load;
    logic             w_outXfer;
    logic [WIDTH-1:0] w_selData;

    rr_arbiter_4 u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .any_req (w_anyReq)
    );

    // A load may happen when the register is empty or is being drained this
    // same cycle; rst suppresses it so no input handshake occurs during reset.
    always_comb begin
        w_outXfer = (r_state == FULL) && out_ready;
        w_load    = !rst && En && w_anyReq && ((r_state == EMPTY) || out_ready);
        w_selData = in_data[int'(w_gnt)*WIDTH +: WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a load always leaves the register FULL; a drain without a
    // replacement empties it; otherwise the current state holds.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (w_load) w_nextState = FULL;
            FULL:    if (w_outXfer && !w_load) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    // Outputs: valid follows the state, ready strobes only the granted channel.
    always_comb begin
        out_valid = (r_state == FULL);
        in_ready  = '0;
        if (w_load) begin
            in_ready = N_CH'(1) << w_gnt;
        end
        out_data = r_data;
        out_sel  = r_sel;
    end

    // Data path: word, source and round-robin pointer change only on a load,
    // which keeps them stable under backpressure and holds ptr when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_load) begin
            r_data <= w_selData;
            r_sel  <= w_gnt;
            r_ptr  <= w_gnt + SEL_W'(1);
        end
    end

endmodule : stream_mux_4to1

// File: tb/tb_stream_mux_4to1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_4to1
// Purpose : Directed self-checking bench for stream_mux_4to1 with WIDTH=8.
//           Inputs change 1ns after a rising edge; outputs are compared 1ns
//           after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_stream_mux_4to1;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             En;
    logic [3:0]       inValid;
    logic [4*WIDTH-1:0] inData;
    logic [3:0]       inReady;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic [1:0]       outSel;
    logic             outReady;

    logic [WIDTH-1:0] chData [4];

    int errorCount = 0;
    int checkCount = 0;

    stream_mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .En        (En),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_data  (outData),
        .out_sel   (outSel),
        .out_ready (outReady)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack the per-channel bench data into the flat input bus.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inData[i*WIDTH +: WIDTH] = chData[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive control inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic rstV, input logic enV,
                                 input logic [3:0] validV, input logic readyV);
        rst      = rstV;
        En       = enV;
        inValid  = validV;
        outReady = readyV;
        #1;
    endtask

    // Advance to 1ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        En       = 1'b1;
        inValid  = 4'b1111;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) chData[i] = 8'hE0 + 8'(i);
        step();

        // Reset held two cycles with every channel requesting.
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1);
        checkOutput("rst_in_ready", 32'(inReady), 32'h0);
        step();
        checkOutput("rst_in_ready_2", 32'(inReady), 32'h0);
        step();
        checkOutput("rst_out_valid", 32'(outValid), 32'h0);
        checkOutput("rst_out_sel", 32'(outSel), 32'h0);
        checkOutput("rst_out_data", 32'(outData), 32'h0);

        // Single channel 2 request.
        chData[2] = 8'hA5;
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1);
        checkOutput("single_in_ready", 32'(inReady), 32'h4);
        step();
        checkOutput("single_out_valid", 32'(outValid), 32'h1);
        checkOutput("single_out_data", 32'(outData), 32'hA5);
        checkOutput("single_out_sel", 32'(outSel), 32'h2);

        // Reset again so the round-robin run starts from channel 0.
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1);
        step();
        checkOutput("rst2_out_valid", 32'(outValid), 32'h0);

        // All channels requesting: one word per cycle in 0,1,2,3,0 order.
        for (int i = 0; i < 4; i++) chData[i] = 8'h10 + 8'(i);
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
        for (int n = 0; n < 5; n++) begin
            checkOutput("rr_in_ready", 32'(inReady), 32'(4'b0001 << (n % 4)));
            step();
            checkOutput("rr_out_valid", 32'(outValid), 32'h1);
            checkOutput("rr_out_sel", 32'(outSel), 32'(n % 4));
            checkOutput("rr_out_data", 32'(outData), 32'(8'h10 + 8'(n % 4)));
        end
        // ptr is now 1.

        // Load 3C from channel 1, then stall for three cycles.
        chData[1] = 8'h3C;
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        step();
        checkOutput("bp_load_data", 32'(outData), 32'h3C);
        chData[1] = 8'h55;
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
        for (int n = 0; n < 3; n++) begin
            checkOutput("bp_in_ready", 32'(inReady), 32'h0);
            step();
            checkOutput("bp_out_valid", 32'(outValid), 32'h1);
            checkOutput("bp_out_data", 32'(outData), 32'h3C);
            checkOutput("bp_out_sel", 32'(outSel), 32'h1);
        end
        // Release: 3C drains and channel 1 loads on the same edge.
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        checkOutput("bp_release_ready", 32'(inReady), 32'h2);
        step();
        checkOutput("bp_release_valid", 32'(outValid), 32'h1);
        checkOutput("bp_release_data", 32'(outData), 32'h55);
        // ptr is now 2.

        // Enable low: no acceptance, the pending word still drains.
        chData[3] = 8'h77;
        applyStimulus(1'b0, 1'b0, 4'b1000, 1'b1);
        checkOutput("en_in_ready", 32'(inReady), 32'h0);
        step();
        checkOutput("en_drain_valid", 32'(outValid), 32'h0);
        checkOutput("en_idle_ready", 32'(inReady), 32'h0);
        step();
        checkOutput("en_idle_valid", 32'(outValid), 32'h0);
        // Enable high with channels 0 and 3 requesting: held ptr=2 picks 3.
        applyStimulus(1'b0, 1'b1, 4'b1001, 1'b1);
        checkOutput("en_resume_ready", 32'(inReady), 32'h8);
        step();
        checkOutput("en_resume_sel", 32'(outSel), 32'h3);
        checkOutput("en_resume_data", 32'(outData), 32'h77);
        // ptr is now 0; load channel 1 so ptr moves to 2.
        chData[1] = 8'h66;
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        step();
        checkOutput("pre_rst_sel", 32'(outSel), 32'h1);

        // Stall, then reset while the word is held.
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        checkOutput("stall_data", 32'(outData), 32'h66);
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'h0);
        step();
        checkOutput("midrst_out_valid", 32'(outValid), 32'h0);
        checkOutput("midrst_out_data", 32'(outData), 32'h0);
        // After release the search restarts at channel 0, not channel 2.
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
        checkOutput("post_rst_ready", 32'(inReady), 32'h1);
        step();
        checkOutput("post_rst_sel", 32'(outSel), 32'h0);
        checkOutput("post_rst_data", 32'(outData), 32'h10);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule : tb_stream_mux_4to1

// File: doc/stream_mux_4to1.md
STREAM_MUX_4TO1 -- requirements
Module: stream_mux_4to1

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per channel.
REQ-002 Parameter: N_CH, fixed 4, number of input channels (not overridable).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 En  input  1  global enable; 0 blocks acceptance of new input data.
REQ-006 in_valid  input  4  per-channel data-valid, bit i = channel i.
REQ-007 in_data  input  4*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  4  per-channel accept strobe, at most one bit high.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_sel  output  2  source channel index of out_data (same encoding as demux select S).
REQ-012 out_ready  input  1  downstream accepts the word when out_valid=1.

Function
REQ-013 Transfer on channel i SHALL occur in a cycle where in_valid[i]=1 and in_ready[i]=1; transfer on output SHALL occur when out_valid=1 and out_ready=1.
REQ-014 load SHALL be defined as En=1 and |in_valid=1 and (out_valid=0 or out_ready=1).
REQ-015 Grant SHALL be round-robin: search channels ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first with in_valid=1.
REQ-016 in_ready SHALL be combinational: in_ready[g]=1 only when load=1 and g is the granted channel; all other bits 0.
REQ-017 On load, the next edge SHALL set out_data=in_data[g], out_sel=g, out_valid=1, ptr=(g+1) mod 4 (wrap 3->0).
REQ-018 Without load, an output transfer SHALL clear out_valid; otherwise out_valid, out_data, out_sel SHALL hold.
REQ-019 Latency input-transfer to out_valid SHALL be exactly 1 cycle.
REQ-020 Simultaneous output transfer and load SHALL replace the word in the same cycle (no bubble); sustained out_ready=1 SHALL give 1 word/cycle.
REQ-021 out_data and out_sel SHALL be stable while out_valid=1 and out_ready=0 (backpressure).
REQ-022 En=0 SHALL block loads and hold ptr; a word already in the output register SHALL still drain on out_ready.
REQ-023 Control state SHALL be two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on load, FULL->EMPTY on output transfer without load, FULL->FULL otherwise if loaded or stalled.
REQ-024 ptr SHALL advance only on load; idle cycles SHALL NOT change ptr.

Reset
REQ-025 rst=1 at an edge SHALL set out_valid=0, out_data=0, out_sel=0, ptr=0, state=EMPTY, overriding any concurrent load.
REQ-026 While rst=1, in_ready SHALL be 4'b0000.
REQ-027 Reset mid-stall SHALL discard the held word; no input transfer occurs in the reset cycle.

Structure
REQ-028 Shared package mux_pkg SHALL hold N_CH=4, SEL_W=2, and the EMPTY/FULL state enum type.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter_4 (inputs req[3:0], ptr[1:0]; outputs gnt index, any_req).
REQ-030 The output register and state machine SHALL reside in stream_mux_4to1.

Verification
REQ-031 Reset: rst=1 two cycles, all in_valid=4'b1111 -> out_valid=0, in_ready=0000, out_sel=00, out_data=0.
REQ-032 Single channel: WIDTH=8, En=1, in_valid=0100, ch2 data=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_sel=10.
REQ-033 Round-robin: in_valid=1111 held, data ch i=8'h10+i, out_ready=1 -> out_sel sequence 00,01,10,11,00, one word/cycle.
REQ-034 Backpressure: out_valid=1 with 8'h3C, out_ready=0 for 3 cycles, in_valid=0010 -> out_data=3C stable, in_ready=0000, ptr unchanged; out_ready=1 -> 3C accepted and ch1 loaded same edge.
REQ-035 Enable: En=0, in_valid=1000 -> in_ready=0000, pending word drains, out_valid falls to 0; En=1 -> ch3 granted next edge, out_sel=11.
REQ-036 Reset mid-operation: rst=1 while out_valid=1, out_ready=0 -> out_valid=0 next edge; after release first grant starts from channel 0.
